// File: rtl/write_bram_control_if.sv
// AXI-lite slave bus bundle for the capture-buffer controller.
// Carries the five AXI-lite channels: AW (address write), W (write data),
// B (write response), AR (address read) and R (read data).
//   master : drives the valid/payload signals and the bready/rready signals
//   slave  : drives the ready signals and the B/R response channels
interface write_bram_control_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]             awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [31:0]             araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/write_bram_control.sv
// Sample-capture buffer controller.
// Stores the incoming sample word into an internal block RAM at a
// programmable decimation rate, either as a single-shot fill or as a ring
// buffer, and exposes the buffer read-only over AXI-lite. AXI-lite writes
// are accepted but answered with SLVERR and never modify the buffer.
// Ports:
//   axi_clock    : single clock for capture and AXI-lite logic
//   rst          : synchronous, active-low reset
//   s_axil       : AXI-lite slave (write channels refused, read channels
//                  return buffer words; index = araddr[ADDR_WIDTH+1:2])
//   din          : sample word, {adc_b in [29:16], adc_a in [13:0]}
//   en_write     : capture runs while high
//   rst_write    : clears capture address, decimation counter, done flag
//   continous    : 1 = ring buffer, 0 = stop when buffer full
//   dec_rate     : one sample stored every dec_rate+1 cycles
//   finish_write : single-shot buffer full
//   wr_addr      : next buffer index to be written
module write_bram_control #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  axi_clock,
  input  logic                  rst,
  write_bram_control_if.slave   s_axil,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  en_write,
  input  logic                  rst_write,
  input  logic                  continous,
  input  logic [31:0]           dec_rate,
  output logic                  finish_write,
  output logic [ADDR_WIDTH-1:0] wr_addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  state_t state, state_next;
  logic   store;

  logic [31:0] dec_cnt;
  logic [31:0] dec_lat;   // decimation period in force for the current count

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rd_pend;
  logic                  rvalid_q;
  logic                  ar_acc;
  logic [ADDR_WIDTH-1:0] rd_index;

  logic aw_done, w_done, bvalid_q;
  logic aw_acc, w_acc, aw_have, w_have;

  // ---------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register in the design samples pre-edge values regardless of block order.
  always_ff @(posedge axi_clock) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every signal gets a default first so no path through the case
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    if (rst_write) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (en_write) state_next = CAPTURE;
        CAPTURE: if (store && wr_addr == LAST_ADDR && !continous) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // The entry cycle out of IDLE stores like a counter=0 cycle in CAPTURE.
  always_comb begin
    store        = 1'b0;
    finish_write = 1'b0;
    case (state)
      IDLE:    store = en_write && !rst_write;
      CAPTURE: store = en_write && !rst_write && (dec_cnt == 32'd0);
      DONE:    finish_write = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Capture address and decimation counter
  // ---------------------------------------------------------------------
  // dec_rate is latched at each wrap so a mid-capture change only alters the
  // period that starts after the current one completes.
  always_ff @(posedge axi_clock) begin
    if (!rst || rst_write) begin
      wr_addr <= '0;
      dec_cnt <= '0;
      dec_lat <= '0;
    end else if (state == IDLE && en_write) begin
      wr_addr <= wr_addr + 1'b1;
      dec_lat <= dec_rate;
      dec_cnt <= (dec_rate == 32'd0) ? 32'd0 : 32'd1;
    end else if (state == CAPTURE && en_write) begin
      if (dec_cnt == dec_lat) begin
        dec_cnt <= '0;
        dec_lat <= dec_rate;
      end else begin
        dec_cnt <= dec_cnt + 32'd1;
      end
      if (store) wr_addr <= wr_addr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Buffer RAM: one capture write port, one AXI read port (read-first)
  // ---------------------------------------------------------------------
  assign rd_index = s_axil.araddr[ADDR_WIDTH+1:2];
  assign ar_acc   = s_axil.arvalid && s_axil.arready;

  // NOTE: the RAM array and its output register have no reset; clearing every
  // word would prevent block-RAM inference, and the contents must survive rst.
  always_ff @(posedge axi_clock) begin
    if (store && rst) mem[wr_addr] <= din;
    if (ar_acc)       rd_q <= mem[rd_index];
  end

  // ---------------------------------------------------------------------
  // AXI-lite read: RAM read on the AR handshake, response one cycle later
  // ---------------------------------------------------------------------
  always_ff @(posedge axi_clock) begin
    if (!rst) begin
      rd_pend  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rd_pend <= ar_acc;
      if (rd_pend) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_q;
      end else if (rvalid_q && s_axil.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s_axil.arready = !(rd_pend || rvalid_q);
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = 2'b00;

  // ---------------------------------------------------------------------
  // AXI-lite write: accept AW and W independently, answer SLVERR
  // ---------------------------------------------------------------------
  assign aw_acc  = s_axil.awvalid && s_axil.awready;
  assign w_acc   = s_axil.wvalid && s_axil.wready;
  assign aw_have = aw_done || aw_acc;
  assign w_have  = w_done || w_acc;

  always_ff @(posedge axi_clock) begin
    if (!rst) begin
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      if (bvalid_q && s_axil.bready) bvalid_q <= 1'b0;
      if (aw_have && w_have) begin
        bvalid_q <= 1'b1;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end else begin
        aw_done <= aw_have;
        w_done  <= w_have;
      end
    end
  end

  assign s_axil.awready = !aw_done && !bvalid_q;
  assign s_axil.wready  = !w_done && !bvalid_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = 2'b10;

  // Write payload, protection bits and address bits outside the buffer index
  // carry no meaning for this block.
  logic unused_axil;
  assign unused_axil = ^{s_axil.awaddr, s_axil.awprot, s_axil.wdata, s_axil.wstrb,
                         s_axil.arprot, s_axil.araddr[31:ADDR_WIDTH+2],
                         s_axil.araddr[1:0]};

endmodule

// File: tb/tb_write_bram_control.sv
// Directed self-checking bench for write_bram_control with a 16-word buffer.
module tb_write_bram_control;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          axi_clock;
  logic          rst;
  logic [31:0]   din;
  logic          en_write;
  logic          rst_write;
  logic          continous;
  logic [31:0]   dec_rate;
  logic          finish_write;
  logic [AW-1:0] wr_addr;

  int n_checks = 0;
  int n_fail   = 0;

  write_bram_control_if #(.DATA_WIDTH(32)) axil ();

  write_bram_control #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .axi_clock    (axi_clock),
    .rst          (rst),
    .s_axil       (axil),
    .din          (din),
    .en_write     (en_write),
    .rst_write    (rst_write),
    .continous    (continous),
    .dec_rate     (dec_rate),
    .finish_write (finish_write),
    .wr_addr      (wr_addr)
  );

  initial begin
    axi_clock = 1'b0;
    forever #5 axi_clock = ~axi_clock;
  end

  typedef struct {
    logic [31:0] araddr;
    logic [31:0] exp_data;
  } rd_vec_t;

  task automatic step();
    @(posedge axi_clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for arready, then completes the AR handshake.
  task automatic ar_phase(input logic [31:0] addr);
    int cnt = 0;
    axil.araddr  = addr;
    axil.arvalid = 1'b1;
    while (!axil.arready && cnt < 20) begin
      step();
      cnt++;
    end
    check("arready_wait", {31'd0, axil.arready}, 32'd1);
    step();
    axil.arvalid = 1'b0;
  endtask

  // Waits (bounded) for rvalid, checks data, stalls rready, then accepts.
  task automatic r_phase(input string name, input logic [31:0] exp, input int stall);
    int cnt = 0;
    axil.rready = 1'b0;
    while (!axil.rvalid && cnt < 20) begin
      step();
      cnt++;
    end
    check({name, "_rvalid"}, {31'd0, axil.rvalid}, 32'd1);
    check({name, "_latency"}, cnt, 32'd1);
    check({name, "_rdata"}, axil.rdata, exp);
    check({name, "_rresp"}, {30'd0, axil.rresp}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      step();
      check({name, "_stall_rvalid"}, {31'd0, axil.rvalid}, 32'd1);
      check({name, "_stall_rdata"}, axil.rdata, exp);
    end
    axil.rready = 1'b1;
    step();
    axil.rready = 1'b0;
    check({name, "_rvalid_clear"}, {31'd0, axil.rvalid}, 32'd0);
  endtask

  task automatic axi_read(input string name, input logic [31:0] addr,
                          input logic [31:0] exp, input int stall);
    ar_phase(addr);
    r_phase(name, exp, stall);
  endtask

  task automatic clear_capture();
    en_write  = 1'b0;
    rst_write = 1'b1;
    step();
    rst_write = 1'b0;
  endtask

  rd_vec_t rd_tbl [6];

  initial begin
    // Buffer contents after the single-shot fill: index k holds A000_0000+k.
    rd_tbl[0] = '{32'h0000_0010, 32'hA000_0004};
    rd_tbl[1] = '{32'h0000_0000, 32'hA000_0000};
    rd_tbl[2] = '{32'h0000_003C, 32'hA000_000F};
    rd_tbl[3] = '{32'h0000_000B, 32'hA000_0002};  // byte offset bits ignored
    rd_tbl[4] = '{32'h1000_0014, 32'hA000_0005};  // upper bits ignored
    rd_tbl[5] = '{32'h0000_0044, 32'hA000_0001};  // bit 6 beyond index ignored

    rst = 1'b0; din = '0; en_write = 1'b0; rst_write = 1'b0;
    continous = 1'b0; dec_rate = '0;
    axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
    axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0; axil.bready = 1'b0;
    axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;

    // ---------------- reset state ----------------
    step(); step();
    check("rst_finish", {31'd0, finish_write}, 32'd0);
    check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("rst_arready", {31'd0, axil.arready}, 32'd1);
    check("rst_awready", {31'd0, axil.awready}, 32'd1);
    check("rst_wready", {31'd0, axil.wready}, 32'd1);
    check("rst_rvalid", {31'd0, axil.rvalid}, 32'd0);
    check("rst_bvalid", {31'd0, axil.bvalid}, 32'd0);
    check("rst_rdata", axil.rdata, 32'd0);
    rst = 1'b1;
    step();

    // ---------------- single-shot fill, dec_rate = 0 ----------------
    en_write = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      din = 32'hA000_0000 + k;
      check("ss_finish_low", {31'd0, finish_write}, 32'd0);
      check("ss_wr_addr", {28'd0, wr_addr}, k);
      step();
    end
    check("ss_finish_high", {31'd0, finish_write}, 32'd1);
    check("ss_wr_addr_wrap", {28'd0, wr_addr}, 32'd0);
    // DONE ignores en_write even with new samples arriving.
    for (int k = 0; k < 4; k++) begin
      din = 32'hDEAD_0000 + k;
      step();
    end
    check("done_finish_hold", {31'd0, finish_write}, 32'd1);
    check("done_wr_addr_hold", {28'd0, wr_addr}, 32'd0);

    // ---------------- table-driven readback ----------------
    for (int i = 0; i < 6; i++)
      axi_read($sformatf("tbl%0d", i), rd_tbl[i].araddr, rd_tbl[i].exp_data, 0);

    // ---------------- rst_write in DONE with en_write high ----------------
    rst_write = 1'b1;
    step();
    check("rw_finish", {31'd0, finish_write}, 32'd0);
    check("rw_wr_addr", {28'd0, wr_addr}, 32'd0);
    rst_write = 1'b0;
    din = 32'hE100_0000;
    step();
    check("rw_restart_addr", {28'd0, wr_addr}, 32'd1);
    clear_capture();

    // ---------------- dec_rate = 3 ----------------
    dec_rate = 32'd3;
    en_write = 1'b1;
    for (int k = 0; k < 12; k++) begin
      din = 32'hB000_0000 + k;
      step();
    end
    en_write = 1'b0;
    check("dec3_wr_addr", {28'd0, wr_addr}, 32'd3);
    axi_read("dec3_idx1", 32'h04, 32'hB000_0004, 0);
    axi_read("dec3_idx2", 32'h08, 32'hB000_0008, 0);
    axi_read("dec3_idx3", 32'h0C, 32'hA000_0003, 0);
    clear_capture();

    // ---------------- dec_rate change mid-capture ----------------
    // Period 2 is in force until its wrap: stores at cycles 0, 3, 4.
    dec_rate = 32'd2;
    en_write = 1'b1;
    step();
    dec_rate = 32'd0;
    for (int k = 0; k < 4; k++) step();
    en_write = 1'b0;
    check("decchg_wr_addr", {28'd0, wr_addr}, 32'd3);
    clear_capture();

    // ---------------- en_write pause ----------------
    en_write = 1'b1;
    for (int n = 0; n < 4; n++) begin
      din = 32'hC000_0000 + n;
      step();
    end
    check("pause_pre_addr", {28'd0, wr_addr}, 32'd4);
    en_write = 1'b0;
    for (int k = 0; k < 10; k++) begin
      din = 32'hDEAD_BEE0 + k;
      step();
      check("pause_frozen_addr", {28'd0, wr_addr}, 32'd4);
    end
    en_write = 1'b1;
    for (int n = 4; n < 8; n++) begin
      din = 32'hC000_0000 + n;
      step();
    end
    en_write = 1'b0;
    check("pause_post_addr", {28'd0, wr_addr}, 32'd8);
    axi_read("pause_idx3", 32'h0C, 32'hC000_0003, 0);
    axi_read("pause_idx4", 32'h10, 32'hC000_0004, 0);
    clear_capture();

    // ---------------- continuous ring, 2*D+5 samples ----------------
    continous = 1'b1;
    en_write  = 1'b1;
    for (int s = 0; s < 2 * DEPTH + 5; s++) begin
      din = 32'hD000_0000 + s;
      step();
      check("ring_finish_low", {31'd0, finish_write}, 32'd0);
    end
    en_write  = 1'b0;
    continous = 1'b0;
    check("ring_wr_addr", {28'd0, wr_addr}, 32'd5);
    axi_read("ring_idx0", 32'h00, 32'hD000_0020, 0);
    axi_read("ring_idx5", 32'h14, 32'hD000_0015, 0);

    // ---------------- AXI write refused, W 3 cycles before AW ----------------
    axil.wdata  = 32'hFFFF_FFFF;
    axil.wvalid = 1'b1;
    step();
    axil.wvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("wr_early_wready", {31'd0, axil.wready}, 32'd0);
      check("wr_early_bvalid", {31'd0, axil.bvalid}, 32'd0);
      step();
    end
    check("wr_awready", {31'd0, axil.awready}, 32'd1);
    axil.awaddr  = 32'h10;
    axil.awvalid = 1'b1;
    step();
    axil.awvalid = 1'b0;
    check("wr_bvalid", {31'd0, axil.bvalid}, 32'd1);
    check("wr_bresp", {30'd0, axil.bresp}, 32'd2);
    check("wr_awready_busy", {31'd0, axil.awready}, 32'd0);
    step(); step();
    check("wr_bvalid_hold", {31'd0, axil.bvalid}, 32'd1);
    axil.bready = 1'b1;
    step();
    axil.bready = 1'b0;
    check("wr_bvalid_clear", {31'd0, axil.bvalid}, 32'd0);
    check("wr_ready_back", {30'd0, axil.awready, axil.wready}, 32'd3);
    axi_read("wr_unchanged_stall", 32'h10, 32'hD000_0024, 5);

    // ---------------- read-first on same-cycle write ----------------
    clear_capture();
    en_write     = 1'b1;
    din          = 32'hE000_0000;
    axil.araddr  = 32'h00;
    axil.arvalid = 1'b1;
    check("rf_arready", {31'd0, axil.arready}, 32'd1);
    step();
    en_write     = 1'b0;
    axil.arvalid = 1'b0;
    r_phase("rf_old", 32'hD000_0020, 0);
    axi_read("rf_new", 32'h00, 32'hE000_0000, 0);
    clear_capture();

    // ---------------- reset mid-capture and mid-AXI ----------------
    en_write = 1'b1;
    for (int k = 0; k < 3; k++) step();
    en_write     = 1'b0;
    axil.awvalid = 1'b1;
    axil.arvalid = 1'b1;
    axil.araddr  = 32'h0;
    step();
    axil.awvalid = 1'b0;
    axil.arvalid = 1'b0;
    check("mid_wr_addr", {28'd0, wr_addr}, 32'd3);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("mid_rst_readies", {29'd0, axil.arready, axil.awready, axil.wready}, 32'd7);
    for (int k = 0; k < 3; k++) begin
      check("mid_rst_no_resp", {30'd0, axil.rvalid, axil.bvalid}, 32'd0);
      step();
    end
    // A lone W after reset must not complete the aborted AW.
    axil.wvalid = 1'b1;
    step();
    axil.wvalid = 1'b0;
    step();
    check("mid_rst_w_only", {29'd0, axil.bvalid, axil.awready, axil.wready}, 32'd2);
    axil.awvalid = 1'b1;
    step();
    axil.awvalid = 1'b0;
    check("mid_rst_b_after_aw", {31'd0, axil.bvalid}, 32'd1);
    axil.bready = 1'b1;
    step();
    axil.bready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
